// File: rtl/cbus_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cbus_ram_responder
//  Description : Word-addressed RAM acting as a cbus responder; serves single
//                and incrementing burst reads/writes, one ready per beat.
//                Optional first-beat latency via macro CBUS_RSP_WAIT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================

package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    localparam logic [3:0] MLEN1  = 4'd0;
    localparam logic [3:0] MLEN4  = 4'd3;
    localparam logic [3:0] MLEN16 = 4'd15;
endpackage

module cbus_ram_responder #(
    parameter int MEM_WORDS   = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  cbus_pkg::cbus_req_t  creq,
    output cbus_pkg::cbus_resp_t cresp,
    output logic                 busy
);

    localparam int c_IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1
`ifdef CBUS_RSP_WAIT_EN
        , S_WAIT = 2'd2
`endif
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_base;
    logic [3:0]           r_len;
    logic [3:0]           r_cnt;
    logic                 r_is_write;
    logic [31:0]          r_mem [MEM_WORDS];
    logic [c_IDX_W-1:0]   w_idx;
    logic                 w_beat;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_unused;

`ifdef CBUS_RSP_WAIT_EN
    logic [3:0]           r_wait;
`else
    localparam int c_wait_cycles_unused = WAIT_CYCLES;
`endif

    // Burst index wraps naturally at the top of the RAM through the truncated add.
    assign w_idx    = r_base + c_IDX_W'(r_cnt);
    assign w_accept = (r_state == S_IDLE) && creq.valid;
    assign busy     = (r_state != S_IDLE);
    assign w_unused = ^{creq.size, creq.addr[31:c_IDX_W+2], creq.addr[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (creq.valid) begin
`ifdef CBUS_RSP_WAIT_EN
                    w_state_nxt = (WAIT_CYCLES != 0) ? S_WAIT : S_BURST;
`else
                    w_state_nxt = S_BURST;
`endif
                end
            end
`ifdef CBUS_RSP_WAIT_EN
            S_WAIT: begin
                if (r_wait <= 4'd1) begin
                    w_state_nxt = S_BURST;
                end
            end
`endif
            S_BURST: begin
                w_beat = 1'b1;
                w_last = (r_cnt == r_len);
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cresp       = '0;
        cresp.ready = w_beat;
        cresp.last  = w_last;
        cresp.data  = w_beat ? r_mem[w_idx] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_base     <= creq.addr[c_IDX_W+1:2];
                r_len      <= creq.len;
                r_is_write <= creq.is_write;
                r_cnt      <= '0;
            end else if (w_beat && !w_last) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

`ifdef CBUS_RSP_WAIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= '0;
        end else if (w_accept) begin
            r_wait <= 4'(WAIT_CYCLES);
        end else if (r_state == S_WAIT) begin
            r_wait <= r_wait - 4'd1;
        end
    end
`endif

    // A beat coinciding with reset is abandoned, so its write is suppressed too.
    always_ff @(posedge clk) begin
        if (w_beat && r_is_write && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (creq.strobe[i]) begin
                    r_mem[w_idx][8*i +: 8] <= creq.data[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
